// File: rtl/regfile_if.sv
// Register-file access bundle: write data/address/enable, read address, read data.
// master drives the port, slave is the register file.
interface regfile_if #(
  parameter int k = 16,
  parameter int n = 3
);
  logic [k-1:0] data_in;
  logic [n-1:0] writenum;
  logic         write;
  logic [n-1:0] readnum;
  logic [k-1:0] data_out;

  modport master (
    output data_in,
    output writenum,
    output write,
    output readnum,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  writenum,
    input  write,
    input  readnum,
    output data_out
  );
endinterface

// File: rtl/regfile.sv
// 8 x 16 register file: one-hot write decode, load-enabled registers,
// combinational 8:1 read mux, asynchronous active-high clear.
module regfile #(
  parameter int k = 16,
  parameter int n = 3
) (
  input  logic [k-1:0] data_in,
  input  logic [n-1:0] writenum,
  input  logic         write,
  input  logic [n-1:0] readnum,
  input  logic         clk,
  output logic [k-1:0] data_out,
  input  logic         reset
);

  logic [7:0]   doutW;
  logic         load0, load1, load2, load3;
  logic         load4, load5, load6, load7;
  logic [k-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  // Decoded independently of write; write only gates the loads.
  assign doutW = 8'b0000_0001 << writenum;

  assign load0 = write & doutW[0];
  assign load1 = write & doutW[1];
  assign load2 = write & doutW[2];
  assign load3 = write & doutW[3];
  assign load4 = write & doutW[4];
  assign load5 = write & doutW[5];
  assign load6 = write & doutW[6];
  assign load7 = write & doutW[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R0 <= '0;
      R1 <= '0;
      R2 <= '0;
      R3 <= '0;
      R4 <= '0;
      R5 <= '0;
      R6 <= '0;
      R7 <= '0;
    end else begin
      if (load0) R0 <= data_in;
      if (load1) R1 <= data_in;
      if (load2) R2 <= data_in;
      if (load3) R3 <= data_in;
      if (load4) R4 <= data_in;
      if (load5) R5 <= data_in;
      if (load6) R6 <= data_in;
      if (load7) R7 <= data_in;
    end
  end

  // No write-through: readers see the old value until the edge.
  always_comb begin
    data_out = '0;
    unique case (readnum)
      3'd0: data_out = R0;
      3'd1: data_out = R1;
      3'd2: data_out = R2;
      3'd3: data_out = R3;
      3'd4: data_out = R4;
      3'd5: data_out = R5;
      3'd6: data_out = R6;
      3'd7: data_out = R7;
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: decode, write/hold, read-during-write,
// async reset and boundary addresses.
module tb_regfile;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  regfile_if #(.k(16), .n(3)) bus ();

  regfile #(.k(16), .n(3)) dut (
    .data_in  (bus.data_in),
    .writenum (bus.writenum),
    .write    (bus.write),
    .readnum  (bus.readnum),
    .clk      (clk),
    .data_out (bus.data_out),
    .reset    (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int i);
    case (i)
      0: rd = dut.R0;
      1: rd = dut.R1;
      2: rd = dut.R2;
      3: rd = dut.R3;
      4: rd = dut.R4;
      5: rd = dut.R5;
      6: rd = dut.R6;
      default: rd = dut.R7;
    endcase
  endfunction

  function automatic logic [15:0] loads();
    loads = {8'h00, dut.load7, dut.load6,
             dut.load5, dut.load4, dut.load3,
             dut.load2, dut.load1, dut.load0};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.writenum = a;
    bus.data_in  = d;
    bus.write    = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  logic [15:0] exp_r [8];

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.data_in  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.readnum  = '0;

    // Reset state: every read is zero.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.readnum = 3'(i);
      #1;
      chk($sformatf("rst_rd%0d", i), bus.data_out, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;

    // Write 42 to R3.
    @(negedge clk);
    bus.data_in  = 16'd42;
    bus.writenum = 3'd3;
    bus.write    = 1'b1;
    bus.readnum  = 3'd3;
    #1;
    chk("w42_doutW", {8'h00, dut.doutW}, 16'h0008);
    chk("w42_load3", {15'h0, dut.load3}, 16'h0001);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    chk("w42_R3", dut.R3, 16'd42);
    chk("w42_dout", bus.data_out, 16'd42);

    // Distinct values everywhere, then combinational sweep.
    for (int i = 0; i < 8; i++) begin
      exp_r[i] = 16'(16'h1111 * (i + 1));
      wr(3'(i), exp_r[i]);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.readnum = 3'(i);
      #1;
      chk($sformatf("sweep%0d", i), bus.data_out, exp_r[i]);
    end

    // Hold: last write wins, then write=0 blocks garbage data.
    @(negedge clk);
    bus.writenum = 3'd5;
    bus.data_in  = 16'hAAAA;
    bus.write    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.data_in  = 16'hBBBB;
    @(posedge clk);
    @(negedge clk);
    bus.write    = 1'b0;
    bus.data_in  = 16'hFFFF;
    exp_r[5]     = 16'hBBBB;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_loads", loads(), 16'h0000);
    for (int i = 0; i < 8; i++)
      chk($sformatf("hold_R%0d", i), rd(i), exp_r[i]);

    // Read during write: old value before edge, new after.
    wr(3'd2, 16'h00AA);
    @(negedge clk);
    bus.readnum  = 3'd2;
    bus.writenum = 3'd2;
    bus.data_in  = 16'h5555;
    bus.write    = 1'b1;
    #1;
    chk("rdw_before", bus.data_out, 16'h00AA);
    @(posedge clk);
    #1;
    chk("rdw_after", bus.data_out, 16'h5555);
    bus.write = 1'b0;

    // Async reset mid-cycle with a pending write to R4.
    @(negedge clk);
    #2;
    bus.writenum = 3'd4;
    bus.data_in  = 16'h1234;
    bus.write    = 1'b1;
    reset        = 1'b1;
    #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("arst_R%0d", i), rd(i), 16'h0000);
    chk("arst_dout", bus.data_out, 16'h0000);
    @(posedge clk);
    #1;
    chk("arst_wr_ign", dut.R4, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    chk("post_rst_wr", dut.R4, 16'h1234);

    // Boundary addresses.
    @(negedge clk);
    bus.writenum = 3'd7;
    bus.data_in  = 16'hFFFF;
    bus.write    = 1'b1;
    #1;
    chk("b7_doutW", {8'h00, dut.doutW}, 16'h0080);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    @(negedge clk);
    bus.writenum = 3'd0;
    bus.data_in  = 16'h8001;
    bus.write    = 1'b1;
    #1;
    chk("b0_doutW", {8'h00, dut.doutW}, 16'h0001);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.readnum = 3'd7;
    #1;
    chk("b7_rd", bus.data_out, 16'hFFFF);
    bus.readnum = 3'd0;
    #1;
    chk("b0_rd", bus.data_out, 16'h8001);
    chk("b_R6", dut.R6, 16'h0000);
    chk("b_R1", dut.R1, 16'h0000);
    chk("b_R4", dut.R4, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
